onehot_decoder: RTL and testbench

ONEHOT_DECODER -- requirements
Module: onehot_decoder

---
 rtl/onehot_decoder_if.sv | 26 ++
 rtl/onehot_decoder.sv | 109 ++++++++++
 tb/tb_onehot_decoder.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/onehot_decoder_if.sv
// Bus bundle for the one-hot decoder: code handshake in, decoded lines and status pulses out.
interface onehot_decoder_if #(
  parameter int decode_width = 16,
  parameter int encode_width = $clog2(decode_width)
);
  logic                    in_valid;
  logic [encode_width-1:0] in_code;
  logic                    in_ready;
  logic                    clear;
  logic [decode_width-1:0] out;
  logic                    out_valid;
  logic                    done;
  logic                    err;

  // The producer presents codes and may abort a hold with clear.
  modport master (
    output in_valid, in_code, clear,
    input  in_ready, out, out_valid, done, err
  );

  // The decoder consumes codes and reports the decoded line plus status pulses.
  modport slave (
    input  in_valid, in_code, clear,
    output in_ready, out, out_valid, done, err
  );
endinterface

// File: rtl/onehot_decoder.sv
// Registered binary-to-one-hot decoder. Each accepted in-range code drives its line
// for hold_cycles cycles; a new code can be taken on the last hold cycle so that
// consecutive codes follow each other without a gap.
module onehot_decoder #(
  parameter int decode_width = 16,
  parameter int encode_width = $clog2(decode_width),
  parameter int hold_cycles  = 4
) (
  input  logic             clk,
  input  logic             rst,
  onehot_decoder_if.slave  bus
);

  localparam int CntW = $clog2(hold_cycles + 1);
  localparam logic [decode_width-1:0] OneLsb = {{(decode_width-1){1'b0}}, 1'b1};
  localparam logic [CntW-1:0] HoldLoad = CntW'(hold_cycles - 1);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [decode_width-1:0] out_q, out_d;
  logic                    outValid_q, outValid_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic [encode_width-1:0] code;
  logic                    inReady;
  logic                    accept;
  logic                    codeInRange;

  // Handshake: ready when idle or on the final hold cycle, never during clear or reset.
  always_comb begin
    code        = bus.in_code;
    inReady     = !rst && !bus.clear && ((state_q == IDLE) || (cnt_q == '0));
    accept      = bus.in_valid && inReady;
    codeInRange = int'(code) < decode_width;
  end

  // Next-state logic: clear aborts, an accept (re)loads, otherwise the hold counts down.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    out_d      = out_q;
    outValid_d = outValid_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    if (bus.clear) begin
      state_d    = IDLE;
      cnt_d      = '0;
      out_d      = '0;
      outValid_d = 1'b0;
    end else if (accept) begin
      // An accept while holding can only happen on the last hold cycle, so it ends that hold.
      done_d = (state_q == HOLD);
      if (codeInRange) begin
        state_d    = HOLD;
        cnt_d      = HoldLoad;
        out_d      = OneLsb << code;
        outValid_d = 1'b1;
      end else begin
        state_d    = IDLE;
        cnt_d      = '0;
        out_d      = '0;
        outValid_d = 1'b0;
        err_d      = 1'b1;
      end
    end else if (state_q == HOLD) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CntW'(1);
      end else begin
        state_d    = IDLE;
        out_d      = '0;
        outValid_d = 1'b0;
        done_d     = 1'b1;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      out_q      <= '0;
      outValid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
      outValid_q <= outValid_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.out       = out_q;
  assign bus.out_valid = outValid_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_onehot_decoder.sv
// Testbench for onehot_decoder: three instances cover the default configuration,
// a narrow decode range with out-of-range codes, and single-cycle holds.
module tb_onehot_decoder;

  // Packed per-cycle observation: {out[15:0], out_valid, done, err, in_ready}.
  typedef logic [19:0] rec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  rec_t expQ[$];

  onehot_decoder_if #(.decode_width(16), .encode_width(4)) ifA ();
  onehot_decoder_if #(.decode_width(10), .encode_width(4)) ifB ();
  onehot_decoder_if #(.decode_width(16), .encode_width(4)) ifC ();

  onehot_decoder #(.decode_width(16), .encode_width(4), .hold_cycles(4)) dutA (
    .clk(clk), .rst(rst), .bus(ifA)
  );
  onehot_decoder #(.decode_width(10), .encode_width(4), .hold_cycles(4)) dutB (
    .clk(clk), .rst(rst), .bus(ifB)
  );
  onehot_decoder #(.decode_width(16), .encode_width(4), .hold_cycles(1)) dutC (
    .clk(clk), .rst(rst), .bus(ifC)
  );

  always #5 clk = ~clk;

  function automatic rec_t mk(logic [15:0] o, logic v, logic d, logic e, logic r);
    return {o, v, d, e, r};
  endfunction

  function automatic rec_t obsA();
    return {ifA.out, ifA.out_valid, ifA.done, ifA.err, ifA.in_ready};
  endfunction

  function automatic rec_t obsB();
    return {6'b0, ifB.out, ifB.out_valid, ifB.done, ifB.err, ifB.in_ready};
  endfunction

  function automatic rec_t obsC();
    return {ifC.out, ifC.out_valid, ifC.done, ifC.err, ifC.in_ready};
  endfunction

  task automatic applyStimulusIdle();
    ifA.in_valid = 1'b0; ifA.in_code = 4'd0; ifA.clear = 1'b0;
    ifB.in_valid = 1'b0; ifB.in_code = 4'd0; ifB.clear = 1'b0;
    ifC.in_valid = 1'b0; ifC.in_code = 4'd0; ifC.clear = 1'b0;
  endtask

  // Reset clears every instance even with a code presented; ready is low during reset.
  task automatic test_reset();
    rec_t got;
    rst = 1'b1;
    applyStimulusIdle();
    ifA.in_valid = 1'b1;
    ifA.in_code  = 4'd5;
    #1;
    checks++;
    if (ifA.in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_ready_low got %b expected 0", ifA.in_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    got = obsA(); checks++;
    if (got !== mk(16'h0, 0, 0, 0, 0)) begin
      errors++; $display("[TB] FAIL reset_state_A got %h expected %h", got, mk(16'h0, 0, 0, 0, 0));
    end
    got = obsB(); checks++;
    if (got !== mk(16'h0, 0, 0, 0, 0)) begin
      errors++; $display("[TB] FAIL reset_state_B got %h expected %h", got, mk(16'h0, 0, 0, 0, 0));
    end
    got = obsC(); checks++;
    if (got !== mk(16'h0, 0, 0, 0, 0)) begin
      errors++; $display("[TB] FAIL reset_state_C got %h expected %h", got, mk(16'h0, 0, 0, 0, 0));
    end
    rst = 1'b0;
    ifA.in_valid = 1'b0;
    #1;
    checks++;
    if ({ifA.in_ready, ifB.in_ready, ifC.in_ready} !== 3'b111) begin
      errors++; $display("[TB] FAIL reset_release_ready got %b expected 111",
                         {ifA.in_ready, ifB.in_ready, ifC.in_ready});
    end
  endtask

  // Code 5 drives line 5 for four cycles, then done pulses and the line drops.
  task automatic test_single();
    rec_t got, exp;
    ifA.in_code  = 4'd5;
    ifA.in_valid = 1'b1;
    for (int k = 0; k < 4; k++) expQ.push_back(mk(16'h0020, 1, 0, 0, (k == 3)));
    expQ.push_back(mk(16'h0000, 0, 1, 0, 1));
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      got = obsA(); exp = expQ.pop_front(); checks++;
      if (got !== exp) begin
        errors++; $display("[TB] FAIL single cycle %0d got %h expected %h", k, got, exp);
      end
      if (k == 0) ifA.in_valid = 1'b0;
    end
  endtask

  // Code 3 then code 9 held on in_valid: lines follow each other with no gap.
  task automatic test_back_to_back();
    rec_t got, exp;
    ifA.in_code  = 4'd3;
    ifA.in_valid = 1'b1;
    for (int k = 0; k < 4; k++) expQ.push_back(mk(16'h0008, 1, 0, 0, (k == 3)));
    for (int k = 0; k < 4; k++) expQ.push_back(mk(16'h0200, 1, (k == 0), 0, (k == 3)));
    expQ.push_back(mk(16'h0000, 0, 1, 0, 1));
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      got = obsA(); exp = expQ.pop_front(); checks++;
      if (got !== exp) begin
        errors++; $display("[TB] FAIL back_to_back cycle %0d got %h expected %h", k, got, exp);
      end
      if (k == 0) ifA.in_code = 4'd9;
      if (k == 4) ifA.in_valid = 1'b0;
    end
  endtask

  // Decode range 10: codes 12 and 10 raise err only; code 9 works; a chained
  // out-of-range code at the end of a hold gives done and err together.
  task automatic test_out_of_range();
    rec_t got, exp;
    ifB.in_code  = 4'd12;
    ifB.in_valid = 1'b1;
    expQ.push_back(mk(16'h0, 0, 0, 1, 1));
    expQ.push_back(mk(16'h0, 0, 0, 1, 1));
    expQ.push_back(mk(16'h0, 0, 0, 0, 1));
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      got = obsB(); exp = expQ.pop_front(); checks++;
      if (got !== exp) begin
        errors++; $display("[TB] FAIL out_of_range cycle %0d got %h expected %h", k, got, exp);
      end
      if (k == 0) ifB.in_code = 4'd10;
      if (k == 1) ifB.in_valid = 1'b0;
    end
    ifB.in_code  = 4'd9;
    ifB.in_valid = 1'b1;
    for (int k = 0; k < 4; k++) expQ.push_back(mk(16'h0200, 1, 0, 0, (k == 3)));
    expQ.push_back(mk(16'h0, 0, 1, 1, 1));
    expQ.push_back(mk(16'h0, 0, 0, 0, 1));
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      got = obsB(); exp = expQ.pop_front(); checks++;
      if (got !== exp) begin
        errors++; $display("[TB] FAIL top_code_chain cycle %0d got %h expected %h", k, got, exp);
      end
      if (k == 0) ifB.in_code = 4'd15;
      if (k == 4) ifB.in_valid = 1'b0;
    end
  endtask

  // Clear on the second hold cycle aborts without done and ignores in_valid.
  task automatic test_clear();
    rec_t got, exp;
    ifA.in_code  = 4'd7;
    ifA.in_valid = 1'b1;
    expQ.push_back(mk(16'h0080, 1, 0, 0, 0));
    expQ.push_back(mk(16'h0080, 1, 0, 0, 0));
    expQ.push_back(mk(16'h0000, 0, 0, 0, 0));
    expQ.push_back(mk(16'h0000, 0, 0, 0, 1));
    expQ.push_back(mk(16'h0000, 0, 0, 0, 1));
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      got = obsA(); exp = expQ.pop_front(); checks++;
      if (got !== exp) begin
        errors++; $display("[TB] FAIL clear cycle %0d got %h expected %h", k, got, exp);
      end
      if (k == 0) ifA.in_valid = 1'b0;
      if (k == 1) begin
        ifA.clear    = 1'b1;
        ifA.in_valid = 1'b1;
        ifA.in_code  = 4'd2;
        #1; checks++;
        if (ifA.in_ready !== 1'b0) begin
          errors++; $display("[TB] FAIL clear_ready_low got %b expected 0", ifA.in_ready);
        end
      end
      if (k == 2) begin
        ifA.clear    = 1'b0;
        ifA.in_valid = 1'b0;
        #1; checks++;
        if (ifA.in_ready !== 1'b1) begin
          errors++; $display("[TB] FAIL clear_ready_after got %b expected 1", ifA.in_ready);
        end
      end
    end
  endtask

  // Reset in the middle of a hold with a code pending: outputs drop, nothing accepted.
  task automatic test_reset_mid_hold();
    rec_t got, exp;
    ifA.in_code  = 4'd4;
    ifA.in_valid = 1'b1;
    expQ.push_back(mk(16'h0010, 1, 0, 0, 0));
    expQ.push_back(mk(16'h0000, 0, 0, 0, 0));
    expQ.push_back(mk(16'h0000, 0, 0, 0, 1));
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      got = obsA(); exp = expQ.pop_front(); checks++;
      if (got !== exp) begin
        errors++; $display("[TB] FAIL reset_mid_hold cycle %0d got %h expected %h", k, got, exp);
      end
      if (k == 0) begin
        rst = 1'b1;
        ifA.in_code = 4'd6;
        #1; checks++;
        if (ifA.in_ready !== 1'b0) begin
          errors++; $display("[TB] FAIL reset_mid_ready_low got %b expected 0", ifA.in_ready);
        end
      end
      if (k == 1) begin
        rst = 1'b0;
        ifA.in_valid = 1'b0;
        #1; checks++;
        if (ifA.in_ready !== 1'b1) begin
          errors++; $display("[TB] FAIL reset_mid_ready_after got %b expected 1", ifA.in_ready);
        end
      end
    end
  endtask

  // Single-cycle hold: codes 0..15 streamed every cycle walk the line upward.
  task automatic test_stream();
    rec_t got, exp;
    logic [15:0] line;
    ifC.in_code  = 4'd0;
    ifC.in_valid = 1'b1;
    expQ.push_back(mk(16'h0001, 1, 0, 0, 1));
    for (int k = 0; k < 17; k++) begin
      @(posedge clk); #1;
      got = obsC(); exp = expQ.pop_front(); checks++;
      if (got !== exp) begin
        errors++; $display("[TB] FAIL stream cycle %0d got %h expected %h", k, got, exp);
      end
      if (k < 15) begin
        ifC.in_code = 4'(k + 1);
        line = 16'h0001 << (k + 1);
        expQ.push_back(mk(line, 1, 1, 0, 1));
      end else if (k == 15) begin
        ifC.in_valid = 1'b0;
        expQ.push_back(mk(16'h0000, 0, 1, 0, 1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_out_of_range();
    test_clear();
    test_reset_mid_hold();
    test_stream();
    checks++;
    if (expQ.size() !== 0) begin
      errors++; $display("[TB] FAIL scoreboard_drain got %0d expected 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
